fpu_intn_to_f32_pipe: RTL and testbench

FPU_INTN_TO_F32_PIPE -- requirements
Module: fpu_intn_to_f32_pipe

---
 rtl/fpu_intn_to_f32_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_fpu_intn_to_f32_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_intn_to_f32_pipe.sv
// fpu_intn_to_f32_pipe: 3-stage integer to IEEE-754 binary32 converter with
// valid/ready handshakes on both sides.
// Configuration macro: FPU_INT2F32_ROUND_MODES_EN. When it is defined, all four
// RMODE encodings are honoured. When it is undefined, RMODE is captured but
// masked, so every conversion rounds to nearest-even.
module fpu_intn_to_f32_pipe #(
  parameter int INT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [INT_WIDTH-1:0] A,
  input  logic                 SIGNED,
  input  logic [1:0]           RMODE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [31:0]          O,
  output logic                 INEXACT
);

  localparam int MW  = INT_WIDTH + 1;           // magnitude width
  localparam int LZW = $clog2(MW + 1);          // leading-zero count width
  localparam logic [LZW-1:0] TOP_IDX = LZW'(MW - 1);
  localparam logic [LZW-1:0] LZ_ONE  = LZW'(1);
`ifdef FPU_INT2F32_ROUND_MODES_EN
  localparam logic [1:0] RM_MASK = 2'b11;
`else
  localparam logic [1:0] RM_MASK = 2'b00;       // forces RNE (encoding 0)
`endif

  // Count leading zeros of the magnitude; an all-zero input returns MW.
  function automatic logic [LZW-1:0] lzc_f(input logic [MW-1:0] v);
    logic [LZW-1:0] cnt;
    logic           done;
    cnt  = '0;
    done = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (done) begin
        cnt = cnt;
      end else if (v[i]) begin
        done = 1'b1;
      end else begin
        cnt = cnt + LZ_ONE;
      end
    end
    return cnt;
  endfunction

  // Pipeline control
  logic s1_v_q, s2_v_q, s3_v_q;
  logic s1_adv_s, s2_adv_s, s3_adv_s, in_fire_s;

  // A stage advances when it holds data and the next stage is empty or leaving.
  always_comb begin
    s3_adv_s  = s3_v_q & OUT_READY;
    s2_adv_s  = s2_v_q & (~s3_v_q | s3_adv_s);
    s1_adv_s  = s1_v_q & (~s2_v_q | s2_adv_s);
    in_fire_s = IN_VALID & IN_READY;
  end

  assign IN_READY = ~RST & (~s1_v_q | s1_adv_s);

  // Stage valid bits: fill from upstream, drain when advancing with no refill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
    end else begin
      s1_v_q <= in_fire_s | (s1_v_q & ~s1_adv_s);
      s2_v_q <= s1_adv_s  | (s2_v_q & ~s2_adv_s);
      s3_v_q <= s2_adv_s  | (s3_v_q & ~s3_adv_s);
    end
  end

  // Stage 1: sign and magnitude
  logic           s1_sign_d, s1_sign_q;
  logic [MW-1:0]  s1_mag_d, s1_mag_q;
  logic [1:0]     s1_rm_q;

  // Negate the sign-extended operand when it is a negative signed value.
  always_comb begin
    s1_sign_d = SIGNED & A[INT_WIDTH-1];
    if (s1_sign_d) begin
      s1_mag_d = ~{A[INT_WIDTH-1], A} + {{(MW-1){1'b0}}, 1'b1};
    end else begin
      s1_mag_d = {1'b0, A};
    end
  end

  // Stage 1 register: capture on input handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s1_rm_q   <= 2'd0;
    end else if (in_fire_s) begin
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s1_rm_q   <= RMODE & RM_MASK;
    end
  end

  // Stage 2: normalisation
  logic [LZW-1:0] lz_s, s2_idx_d, s2_idx_q;
  logic [MW-1:0]  s2_norm_d, s2_norm_q;
  logic           s2_sign_q;
  logic [1:0]     s2_rm_q;

  // Shift the leading one to the top bit; its original index sets the exponent.
  always_comb begin
    lz_s      = lzc_f(s1_mag_q);
    s2_norm_d = s1_mag_q << lz_s;
    s2_idx_d  = TOP_IDX - lz_s;
  end

  // Stage 2 register: load when stage 1 advances.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_sign_q <= 1'b0;
      s2_norm_q <= '0;
      s2_idx_q  <= '0;
      s2_rm_q   <= 2'd0;
    end else if (s1_adv_s) begin
      s2_sign_q <= s1_sign_q;
      s2_norm_q <= s2_norm_d;
      s2_idx_q  <= s2_idx_d;
      s2_rm_q   <= s1_rm_q;
    end
  end

  // Stage 3: round and pack
  logic [22:0] mant_s;
  logic        guard_s, sticky_s, zero_s;

  // Operands of 24 bits or fewer always fit the significand, so nothing is dropped.
  generate
    if (INT_WIDTH > 24) begin : g_round
      assign mant_s   = s2_norm_q[MW-2 -: 23];
      assign guard_s  = s2_norm_q[MW-25];
      assign sticky_s = |s2_norm_q[MW-26:0];
    end else begin : g_exact
      logic [MW+22:0] ext_s;
      assign ext_s    = {s2_norm_q, 23'd0};
      assign mant_s   = ext_s[MW+21 -: 23];
      assign guard_s  = 1'b0;
      assign sticky_s = 1'b0;
    end
  endgenerate

  assign zero_s = ~s2_norm_q[MW-1];

  logic        inc_s, inx_d, inx_q;
  logic [23:0] mant_rnd_s;
  logic [7:0]  exp_s;
  logic [31:0] o_d, o_q;

  // Rounding decision, carry-out into the exponent, and final packing.
  always_comb begin
    case (s2_rm_q)
      2'd0:    inc_s = guard_s & (sticky_s | mant_s[0]);
      2'd1:    inc_s = 1'b0;
      2'd2:    inc_s = ~s2_sign_q & (guard_s | sticky_s);
      2'd3:    inc_s = s2_sign_q & (guard_s | sticky_s);
      default: inc_s = 1'b0;
    endcase
    mant_rnd_s = {1'b0, mant_s} + {23'd0, inc_s};
    exp_s      = 8'd127 + {{(8-LZW){1'b0}}, s2_idx_q};
    if (mant_rnd_s[23]) begin
      exp_s = exp_s + 8'd1;
    end else begin
      exp_s = exp_s;
    end
    if (zero_s) begin
      o_d   = 32'd0;
      inx_d = 1'b0;
    end else begin
      o_d   = {s2_sign_q, exp_s, mant_rnd_s[22:0]};
      inx_d = guard_s | sticky_s;
    end
  end

  // Stage 3 register: load when stage 2 advances, hold under backpressure.
  always_ff @(posedge CLK) begin
    if (RST) begin
      o_q   <= 32'd0;
      inx_q <= 1'b0;
    end else if (s2_adv_s) begin
      o_q   <= o_d;
      inx_q <= inx_d;
    end
  end

  // Outputs read as idle during a reset cycle.
  assign OUT_VALID = s3_v_q & ~RST;
  assign O         = RST ? 32'd0 : o_q;
  assign INEXACT   = inx_q & ~RST;

endmodule

// File: tb/tb_fpu_intn_to_f32_pipe.sv
// Self-checking bench for fpu_intn_to_f32_pipe (INT_WIDTH = 32).
module tb_fpu_intn_to_f32_pipe;
  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST, IN_VALID, IN_READY, SIGNED, OUT_VALID, OUT_READY, INEXACT;
  logic [W-1:0]  A;
  logic [1:0]    RMODE;
  logic [31:0]   O;

  int checks = 0;
  int errors = 0;

  fpu_intn_to_f32_pipe #(.INT_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .SIGNED(SIGNED), .RMODE(RMODE), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .O(O), .INEXACT(INEXACT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference conversion from the arithmetic value: {inexact, binary32}.
  function automatic logic [32:0] ref_conv(input logic [W-1:0] a, input logic sg,
                                           input logic [1:0] rm);
    longint unsigned mag, q, rem, half;
    bit neg, inc;
    int e, sh;
    logic [1:0] mode;
`ifdef FPU_INT2F32_ROUND_MODES_EN
    mode = rm;
`else
    mode = 2'd0;
`endif
    neg = sg && a[W-1];
    mag = neg ? ((64'd1 << W) - {32'd0, a}) : {32'd0, a};
    if (mag == 0) return 33'd0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = mag << (23 - e); rem = 0; half = 1;
    end else begin
      sh = e - 23;
      q = mag >> sh;
      rem = mag - (q << sh);
      half = 64'd1 << (sh - 1);
    end
    case (mode)
      2'd0:    inc = (rem > half) || (rem == half && q[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = !neg && rem != 0;
      default: inc = neg && rem != 0;
    endcase
    q = q + {63'd0, inc};
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    return {rem != 0, neg, 8'(e + 127), q[22:0]};
  endfunction

  typedef struct { logic [31:0] o; logic inx; } exp_t;
  exp_t sbq[$];

  // Scoreboard monitor: model every accepted operand, compare every transfer.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_o;
    logic        prev_inx;
    logic [32:0] r;
    exp_t        e;
    prev_stall = 1'b0; prev_o = 32'd0; prev_inx = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        sbq.delete();
        prev_stall = 1'b0;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_o", O, 0);
        chk("rst_inexact", INEXACT, 0);
        chk("rst_in_ready", IN_READY, 0);
      end else begin
        if (prev_stall) begin
          chk("hold_valid", OUT_VALID, 1);
          chk("hold_o", O, prev_o);
          chk("hold_inexact", INEXACT, prev_inx);
        end
        if (OUT_VALID) begin
          if (sbq.size() == 0) begin
            chk("spurious_out", OUT_VALID, 0);
          end else if (OUT_READY) begin
            e = sbq.pop_front();
            chk("sb_o", O, e.o);
            chk("sb_inexact", INEXACT, e.inx);
          end
        end
        if (IN_VALID && IN_READY) begin
          r = ref_conv(A, SIGNED, RMODE);
          sbq.push_back('{o: r[31:0], inx: r[32]});
        end
        prev_stall = OUT_VALID && !OUT_READY;
        prev_o = O;
        prev_inx = INEXACT;
      end
    end
  end

  typedef struct {
    logic [31:0] a; logic s; logic [1:0] rm; logic [31:0] eo; logic ei;
  } vec_t;
  vec_t tbl[13];

  // Present one operand, wait for its result, check value and 3-cycle latency.
  task automatic send_check(input string nm, input logic [31:0] a, input logic s,
                            input logic [1:0] rm, input logic [31:0] eo, input logic ei);
    int lat; bit got;
    @(posedge CLK); #1;
    OUT_READY = 1'b1; IN_VALID = 1'b1; A = a; SIGNED = s; RMODE = rm;
    @(negedge CLK);
    chk({nm, "_in_ready"}, IN_READY, 1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 0; got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge CLK);
      lat++;
      if (OUT_VALID) begin
        got = 1;
        chk({nm, "_o"}, O, eo);
        chk({nm, "_inexact"}, INEXACT, ei);
        chk({nm, "_latency"}, lat, 3);
      end
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [31:0] bp_a[5];
    exp_t        bp_e[5];
    logic [32:0] r;
    int ntx, nrx, cyc, acc_at6;
    bit acc;

    tbl[0]  = '{32'h80000000, 1'b1, 2'd0, 32'hCF000000, 1'b0};
    tbl[1]  = '{32'h80000000, 1'b0, 2'd0, 32'h4F000000, 1'b0};
    tbl[2]  = '{32'h01000001, 1'b0, 2'd0, 32'h4B800000, 1'b1};
`ifdef FPU_INT2F32_ROUND_MODES_EN
    tbl[3]  = '{32'h01000001, 1'b0, 2'd2, 32'h4B800001, 1'b1};
    tbl[5]  = '{32'hFEFFFFFF, 1'b1, 2'd3, 32'hCB800001, 1'b1};
    tbl[6]  = '{32'hFFFFFFFF, 1'b0, 2'd1, 32'h4F7FFFFF, 1'b1};
`else
    tbl[3]  = '{32'h01000001, 1'b0, 2'd2, 32'h4B800000, 1'b1};
    tbl[5]  = '{32'hFEFFFFFF, 1'b1, 2'd3, 32'hCB800000, 1'b1};
    tbl[6]  = '{32'hFFFFFFFF, 1'b0, 2'd1, 32'h4F800000, 1'b1};
`endif
    tbl[4]  = '{32'h01000001, 1'b0, 2'd1, 32'h4B800000, 1'b1};
    tbl[7]  = '{32'hFFFFFFFF, 1'b0, 2'd0, 32'h4F800000, 1'b1};
    tbl[8]  = '{32'h00000000, 1'b1, 2'd0, 32'h00000000, 1'b0};
    tbl[9]  = '{32'h00000000, 1'b0, 2'd2, 32'h00000000, 1'b0};
    tbl[10] = '{32'h00000001, 1'b1, 2'd0, 32'h3F800000, 1'b0};
    tbl[11] = '{32'hFFFFFFFF, 1'b1, 2'd0, 32'hBF800000, 1'b0};
    tbl[12] = '{32'h00FFFFFF, 1'b0, 2'd0, 32'h4B7FFFFF, 1'b0};

    RST = 1'b1; IN_VALID = 1'b0; A = '0; SIGNED = 1'b0; RMODE = 2'd0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_in_ready", IN_READY, 1);
    chk("post_rst_out_valid", OUT_VALID, 0);

    // Directed vectors
    for (int i = 0; i < 13; i++)
      send_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].s, tbl[i].rm, tbl[i].eo, tbl[i].ei);

    // Back-to-back +1 / -1: results in consecutive cycles at +3 and +4
    @(posedge CLK); #1;
    OUT_READY = 1'b1; IN_VALID = 1'b1; A = 32'h1; SIGNED = 1'b1; RMODE = 2'd0;
    @(negedge CLK); chk("b2b_rdy0", IN_READY, 1);
    @(posedge CLK); #1; A = 32'hFFFFFFFF;
    @(negedge CLK); chk("b2b_rdy1", IN_READY, 1);
    @(posedge CLK); #1; IN_VALID = 1'b0;
    @(negedge CLK); chk("b2b_c2_valid", OUT_VALID, 0);
    @(negedge CLK); chk("b2b_c3_valid", OUT_VALID, 1);
    chk("b2b_c3_o", O, 32'h3F800000); chk("b2b_c3_inexact", INEXACT, 0);
    @(negedge CLK); chk("b2b_c4_valid", OUT_VALID, 1);
    chk("b2b_c4_o", O, 32'hBF800000); chk("b2b_c4_inexact", INEXACT, 0);
    @(negedge CLK); chk("b2b_c5_valid", OUT_VALID, 0);

    // Backpressure: 5 operands, OUT_READY low for 6 cycles
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = $urandom();
      r = ref_conv(bp_a[i], 1'b1, 2'd0);
      bp_e[i] = '{o: r[31:0], inx: r[32]};
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b0; IN_VALID = 1'b1; A = bp_a[0]; SIGNED = 1'b1; RMODE = 2'd0;
    ntx = 0; nrx = 0; acc_at6 = -1;
    for (cyc = 0; cyc < 40 && nrx < 5; cyc++) begin
      @(negedge CLK);
      acc = IN_VALID && IN_READY;
      if (OUT_VALID && OUT_READY) begin
        chk($sformatf("bp_o%0d", nrx), O, bp_e[nrx].o);
        chk($sformatf("bp_inexact%0d", nrx), INEXACT, bp_e[nrx].inx);
        nrx++;
      end
      @(posedge CLK); #1;
      if (acc) begin
        ntx++;
        if (ntx < 5) A = bp_a[ntx]; else IN_VALID = 1'b0;
      end
      if (cyc == 5) begin
        acc_at6 = ntx;
        OUT_READY = 1'b1;
      end
    end
    IN_VALID = 1'b0;
    chk("bp_accepted_while_stalled", acc_at6, 3);
    chk("bp_results", nrx, 5);

    // Reset with two operands in flight
    OUT_READY = 1'b1; IN_VALID = 1'b1; A = 32'h12345678; SIGNED = 1'b0;
    @(posedge CLK); #1; A = 32'h87654321; SIGNED = 1'b1;
    @(posedge CLK); #1; IN_VALID = 1'b0; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK); chk("mid_rst_in_ready", IN_READY, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid_rst_no_out%0d", k), OUT_VALID, 0);
      @(negedge CLK);
    end
    send_check("post_rst", 32'h01000003, 1'b0, 2'd0, 32'h4B800002, 1'b1);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 600; n++) begin
      @(negedge CLK);
      acc = IN_VALID && IN_READY;
      @(posedge CLK); #1;
      if (acc || !IN_VALID) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        A = $urandom() >> $urandom_range(0, 31);
        if ($urandom_range(0, 3) == 0) A = ~A;
        SIGNED = $urandom_range(0, 1) == 1;
        RMODE = 2'($urandom_range(0, 3));
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge CLK);
    @(negedge CLK);
    chk("drain_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
